// File: rtl/piso_serializer_if.sv
// Load-side and serial-side signals of the PISO serializer, bundled for port use.
// Latency: none, wiring only.
// Backpressure: load_ready from the slave throttles load_valid from the master.
interface piso_serializer_if #(
  parameter int DATA_W = 8
);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  // Parallel load handshake
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic              lsb_first;

  // Serial line side
  logic              shift_en;
  logic              serial_out;
  logic              serial_valid;
  logic              busy;
  logic [IDX_W-1:0]  bit_idx;
  logic              done;

  // Producer / line-driver side
  modport master (
    output load_valid,
    output load_data,
    output lsb_first,
    output shift_en,
    input  load_ready,
    input  serial_out,
    input  serial_valid,
    input  busy,
    input  bit_idx,
    input  done
  );

  // Serializer side
  modport slave (
    input  load_valid,
    input  load_data,
    input  lsb_first,
    input  shift_en,
    output load_ready,
    output serial_out,
    output serial_valid,
    output busy,
    output bit_idx,
    output done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with runtime bit order and strobe-gated shifting.
// Latency: first bit on serial_out one cycle after the accepting edge; done one cycle after the last bit.
// Backpressure: load_ready only in IDLE or in the consumed last-bit cycle, so back-to-back frames have no gap.
module piso_serializer #(
  parameter int   DATA_W     = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input logic         clk,
  input logic         rst,
  piso_serializer_if.slave bus
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q,   state_d;
  logic [DATA_W-1:0] shreg_q,   shreg_d;
  logic              lsb_q,     lsb_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              done_q,    done_d;

  logic last_bit;
  logic load_ready;
  logic accept;

  // Last bit is consumed when the strobe arrives while bit_idx points at the final bit.
  assign last_bit   = (state_q == SHIFT) && (bit_idx_q == LAST_IDX) && bus.shift_en;
  assign load_ready = (state_q == IDLE) || last_bit;
  assign accept     = bus.load_valid && load_ready;

  // State, shift register, order latch, bit counter and done pulse registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      lsb_q     <= 1'b0;
      bit_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      lsb_q     <= lsb_d;
      bit_idx_q <= bit_idx_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: load on handshake, shift on strobe, close or chain the frame at the last bit.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    lsb_d     = lsb_q;
    bit_idx_d = bit_idx_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d   = bus.load_data;
          lsb_d     = bus.lsb_first;
          bit_idx_d = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (bus.shift_en) begin
          if (bit_idx_q == LAST_IDX) begin
            done_d    = 1'b1;
            bit_idx_d = '0;
            if (accept) begin
              // Chain the next frame at the same edge: no idle cycle on the line.
              shreg_d = bus.load_data;
              lsb_d   = bus.lsb_first;
              state_d = SHIFT;
            end else begin
              shreg_d = '0;
              state_d = IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            // The outgoing bit always sits at one end; shift toward it.
            if (lsb_q) begin
              shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
            end else begin
              shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output drive: frame bit from the active end of the shift register, idle level otherwise.
  always_comb begin
    bus.serial_out   = IDLE_LEVEL;
    bus.serial_valid = 1'b0;
    bus.busy         = 1'b0;
    if (state_q == SHIFT) begin
      bus.serial_out   = lsb_q ? shreg_q[0] : shreg_q[DATA_W-1];
      bus.serial_valid = 1'b1;
      bus.busy         = 1'b1;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.bit_idx    = bit_idx_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer with DATA_W=8, IDLE_LEVEL=0.
// Latency: inputs driven 1ns after the rising edge, outputs checked 1ns later.
// Backpressure: exercised through held load_valid across in-flight frames.
module tb_piso_serializer;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  piso_serializer_if #(.DATA_W(W)) bus ();

  piso_serializer #(.DATA_W(W), .IDLE_LEVEL(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out"},  32'(bus.serial_out),   32'd0);
    chk({tag, "_vld"},  32'(bus.serial_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy),         32'd0);
  endtask

  // One full frame with shift_en held high; seq[i] is the i-th transmitted bit.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic lsb, input logic [7:0] seq);
    bus.load_data  = d;
    bus.lsb_first  = lsb;
    bus.load_valid = 1'b1;
    bus.shift_en   = 1'b1;
    #1;
    chk({tag, "_rdy_idle"}, 32'(bus.load_ready), 32'd1);
    step();
    bus.load_valid = 1'b0;
    bus.lsb_first  = ~lsb;
    #1;
    for (int i = 0; i < W; i++) begin
      chk({tag, "_vld"},  32'(bus.serial_valid), 32'd1);
      chk({tag, "_bit"},  32'(bus.serial_out),   32'(seq[i]));
      chk({tag, "_idx"},  32'(bus.bit_idx),      32'(i));
      chk({tag, "_done"}, 32'(bus.done),         32'd0);
      chk({tag, "_rdy"},  32'(bus.load_ready),   32'(i == W - 1));
      step();
      #1;
    end
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd1);
    chk_idle({tag, "_end"});
    step();
    #1;
    chk({tag, "_done_clear"}, 32'(bus.done), 32'd0);
  endtask

  logic [7:0] seq;

  initial begin
    // Reset with random inputs
    rst            = 1'b0;
    bus.load_valid = 1'($urandom_range(0, 1));
    bus.load_data  = 8'($urandom);
    bus.lsb_first  = 1'($urandom_range(0, 1));
    bus.shift_en   = 1'($urandom_range(0, 1));
    step();
    bus.load_valid = 1'($urandom_range(0, 1));
    bus.shift_en   = 1'($urandom_range(0, 1));
    step();
    #1;
    chk_idle("rst");
    chk("rst_done", 32'(bus.done),       32'd0);
    chk("rst_rdy",  32'(bus.load_ready), 32'd1);
    chk("rst_idx",  32'(bus.bit_idx),    32'd0);
    bus.load_valid = 1'b0;
    bus.shift_en   = 1'b0;
    rst            = 1'b1;
    step();
    chk("post_rst_done", 32'(bus.done), 32'd0);

    // LSB-first A5: 1,0,1,0,0,1,0,1
    run_frame("lsb_a5", 8'hA5, 1'b1, 8'hA5);
    // MSB-first A5: bit7..bit0 = 1,0,1,0,0,1,0,1
    run_frame("msb_a5", 8'hA5, 1'b0, 8'hA5);
    // MSB-first 01: seven zeros then a one
    run_frame("msb_01", 8'h01, 1'b0, 8'h80);

    // Gated shifting: strobe every 3rd cycle, each bit held 3 cycles
    seq            = 8'h3C;
    bus.load_data  = 8'h3C;
    bus.lsb_first  = 1'b1;
    bus.load_valid = 1'b1;
    bus.shift_en   = 1'b0;
    #1;
    chk("gate_rdy_idle", 32'(bus.load_ready), 32'd1);
    step();
    bus.load_valid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      bus.shift_en = (c % 3 == 2);
      #1;
      chk("gate_vld",  32'(bus.serial_valid), 32'd1);
      chk("gate_bit",  32'(bus.serial_out),   32'(seq[c / 3]));
      chk("gate_idx",  32'(bus.bit_idx),      32'(c / 3));
      chk("gate_done", 32'(bus.done),         32'd0);
      step();
    end
    bus.shift_en = 1'b0;
    #1;
    chk("gate_done_pulse", 32'(bus.done), 32'd1);
    chk_idle("gate_end");
    step();
    chk("gate_done_clear", 32'(bus.done), 32'd0);

    // Back-to-back: FF then 00, 16 contiguous valid bits
    bus.load_data  = 8'hFF;
    bus.lsb_first  = 1'b1;
    bus.load_valid = 1'b1;
    bus.shift_en   = 1'b1;
    step();
    bus.load_data = 8'h00;
    for (int c = 0; c < 16; c++) begin
      if (c >= 8) bus.load_valid = 1'b0;
      #1;
      chk("b2b_vld",  32'(bus.serial_valid), 32'd1);
      chk("b2b_bit",  32'(bus.serial_out),   32'(c < 8));
      chk("b2b_idx",  32'(bus.bit_idx),      32'(c % 8));
      chk("b2b_done", 32'(bus.done),         32'(c == 8));
      chk("b2b_rdy",  32'(bus.load_ready),   32'((c == 7) || (c == 15)));
      step();
    end
    #1;
    chk("b2b_done_end", 32'(bus.done), 32'd1);
    chk_idle("b2b_end");
    step();
    chk("b2b_done_clear", 32'(bus.done), 32'd0);

    // Handshake: 81 offered at bit_idx=3 of an in-flight A5 frame
    seq            = 8'hA5;
    bus.load_data  = 8'hA5;
    bus.lsb_first  = 1'b1;
    bus.load_valid = 1'b1;
    bus.shift_en   = 1'b1;
    step();
    bus.load_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) begin
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h81;
        bus.lsb_first  = 1'b0;
      end
      #1;
      chk("hs_bit", 32'(bus.serial_out), 32'(seq[c]));
      chk("hs_idx", 32'(bus.bit_idx),    32'(c));
      chk("hs_rdy", 32'(bus.load_ready), 32'(c == 7));
      step();
    end
    bus.load_valid = 1'b0;
    seq            = 8'h81;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("hs2_vld",  32'(bus.serial_valid), 32'd1);
      chk("hs2_bit",  32'(bus.serial_out),   32'(seq[c]));
      chk("hs2_done", 32'(bus.done),         32'(c == 0));
      step();
    end
    #1;
    chk("hs2_done_end", 32'(bus.done), 32'd1);
    chk_idle("hs2_end");
    step();

    // Reset mid-frame: frame dropped, no done pulse
    bus.load_data  = 8'hA5;
    bus.lsb_first  = 1'b1;
    bus.load_valid = 1'b1;
    bus.shift_en   = 1'b1;
    step();
    bus.load_valid = 1'b0;
    step();
    step();
    #1;
    chk("mid_idx", 32'(bus.bit_idx), 32'd2);
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_done", 32'(bus.done),       32'd0);
    chk("mid_rst_idx",  32'(bus.bit_idx),    32'd0);
    chk("mid_rst_rdy",  32'(bus.load_ready), 32'd1);
    step();
    chk("mid_after_done", 32'(bus.done),         32'd0);
    chk("mid_after_vld",  32'(bus.serial_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out serializer; successor to the fixed 4-bit PISO register.
- Adds configurable width, runtime bit-order select, an external shift-enable tick, a valid/ready load handshake, back-to-back frames and a frame-done pulse.
- Sits between a parallel producer (FIFO or FSM) and a serial line driver (UART/SPI-style TX path).

Parameters:
- DATA_W, 8, frame width in bits (>=2).
- IDLE_LEVEL, 1'b0, value driven on serial_out when no frame is active.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset: sampled on rising edge of clk, active when 0.
- load_valid  in  1  producer presents load_data.
- load_ready  out  1  serializer accepts load_data this cycle.
- load_data  in  DATA_W  parallel word.
- lsb_first  in  1  bit order, sampled only at load: 1 = bit 0 first, 0 = bit DATA_W-1 first.
- shift_en  in  1  bit-advance tick (baud/strobe); may be held at 1.
- serial_out  out  1  current serial bit.
- serial_valid  out  1  serial_out carries a frame bit.
- busy  out  1  frame in progress (equals serial_valid).
- bit_idx  out  $clog2(DATA_W)  index (0-based, in transmit order) of the bit currently on serial_out.
- done  out  1  one-cycle pulse after the last bit of a frame is consumed.

Behaviour:
- Reset (rst==0 at edge):
  - State IDLE; shift register 0; bit_idx 0.
  - serial_out=IDLE_LEVEL; serial_valid=0; busy=0; done=0.
  - load_ready is combinational and equals 1 in IDLE, so it is 1 after reset.
  - Reset mid-frame drops the frame silently: no done pulse.
- States:
  - IDLE: load_ready=1. On load_valid&&load_ready: capture load_data and lsb_first, set bit_idx=0, go SHIFT.
  - SHIFT: serial_valid=busy=1.
    - serial_out = data[bit_idx] if the latched lsb_first=1, else data[DATA_W-1-bit_idx]; a shift register may implement this.
    - shift_en=1 with bit_idx<DATA_W-1: bit_idx increments next cycle. shift_en=0: hold.
    - Last bit (bit_idx==DATA_W-1) with shift_en=1: frame ends; done=1 on the next cycle.
- Latency: the first bit appears on serial_out in the cycle after the accepting edge.
- Frame length: exactly DATA_W shift_en-qualified SHIFT cycles.
- load_ready = IDLE || (SHIFT && bit_idx==DATA_W-1 && shift_en), combinational.
- Back-to-back: if load_valid is high in that last-bit cycle, the new word is captured at the same edge.
  - The next cycle shows bit 0 of the new frame with serial_valid still 1 (no idle gap); done pulses in that cycle.
- No accept in the last-bit cycle: next state IDLE, serial_out=IDLE_LEVEL, done=1.
- load_valid while SHIFT and not at the last bit: ignored (load_ready=0). The producer must hold load_data stable until the handshake.
- lsb_first changes during a frame have no effect.
- shift_en in IDLE: ignored.
- done never asserts for more than one consecutive cycle per frame.

Test Plan:
- Reset: rst=0 for 2 cycles with random inputs -> serial_out=IDLE_LEVEL, serial_valid=0, done=0, load_ready=1; rst=0 mid-frame -> frame aborted, no done.
- LSB-first, DATA_W=8, shift_en=1: load 8'hA5, lsb_first=1 -> serial_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept; done 1 cycle after the 8th bit; then IDLE_LEVEL.
- MSB-first: load 8'hA5, lsb_first=0 -> 1,0,1,0,0,1,0,1 (bit7..bit0); repeat with 8'h01 -> seven 0s then 1.
- Gated shifting: shift_en high every 3rd cycle, load 8'h3C -> each bit held 3 cycles, bit_idx steps 0..7, total frame 24 cycles, single done pulse.
- Back-to-back: load_valid held with 8'hFF then 8'h00 -> 16 contiguous valid bits (8 ones, 8 zeros), serial_valid never drops, done pulses once between frames and once at end.
- Handshake: load_valid asserted at bit_idx=3 with 8'h81 -> load_ready=0, not accepted until last-bit cycle; the in-flight frame completes uncorrupted.
